// File: rtl/sram_monitor_pkg.sv
// Shared types and helpers for the SRAM write monitor and its per-region trackers.
package sram_monitor_pkg;

  typedef enum logic [1:0] {
    S_MON_IDLE  = 2'd0,
    S_MON_ARMED = 2'd1,
    S_MON_DONE  = 2'd2
  } monitor_state_t;

  localparam logic [15:0] DEFAULT_SIG_POLY = 16'h1021;

  // Increment that sticks at max_val; callers cast to their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sram_region_tracker.sv
// Per-region statistics: saturating write count, MISR signature and sequentiality check.
module sram_region_tracker
  import sram_monitor_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 18,
  parameter int unsigned     DATA_W   = 16,
  parameter int unsigned     CNT_W    = 18,
  parameter logic [DATA_W-1:0] SIG_POLY = DATA_W'(DEFAULT_SIG_POLY)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              clear_i,
  input  logic              hit_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [DATA_W-1:0] sig_o,
  output logic              nonseq_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              seen_q, seen_d;
  logic [ADDR_W-1:0] next_addr;

  always_comb begin
    count_d     = count_q;
    sig_d       = sig_q;
    last_addr_d = last_addr_q;
    seen_d      = seen_q;
    // Wraps modulo 2^ADDR_W, so the top word followed by word 0 counts as sequential.
    next_addr   = last_addr_q + ADDR_W'(1);
    nonseq_o    = hit_i & seen_q & (addr_i != next_addr);
    if (clear_i) begin
      count_d     = '0;
      sig_d       = '0;
      last_addr_d = '0;
      seen_d      = 1'b0;
    end else if (hit_i) begin
      count_d     = CNT_W'(sat_inc(32'(count_q), 32'(CntMax)));
      sig_d       = {sig_q[DATA_W-2:0], 1'b0} ^ (sig_q[DATA_W-1] ? SIG_POLY : '0) ^ data_i;
      last_addr_d = addr_i;
      seen_d      = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      count_q     <= '0;
      sig_q       <= '0;
      last_addr_q <= '0;
      seen_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      sig_q       <= sig_d;
      last_addr_q <= last_addr_d;
      seen_q      <= seen_d;
    end
  end

  assign count_o = count_q;
  assign sig_o   = sig_q;

endmodule

// File: rtl/sram_write_monitor.sv
// Snoops the SRAM write port: region bounds, per-region counts/signatures,
// sequentiality and first-violation capture, gated by an IDLE/ARMED/DONE window.
module sram_write_monitor
  import sram_monitor_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 18,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       NUM_REGIONS = 2,
  parameter int unsigned       CNT_W       = 18,
  parameter int unsigned       MAX_VIOL    = 15,
  parameter logic [DATA_W-1:0] SIG_POLY    = DATA_W'(DEFAULT_SIG_POLY)
) (
  input  logic                                 Clock,
  input  logic                                 Resetn,
  input  logic                                 start_i,
  input  logic                                 stop_i,
  input  logic                                 clear_i,
  input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]   region_lo_i,
  input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]   region_hi_i,
  input  logic                                 sram_we_n_i,
  input  logic [ADDR_W-1:0]                    sram_address_i,
  input  logic [DATA_W-1:0]                    sram_write_data_i,
  output logic [1:0]                           state_o,
  output logic [NUM_REGIONS-1:0][CNT_W-1:0]    region_count_o,
  output logic [NUM_REGIONS-1:0][DATA_W-1:0]   signature_o,
  output logic [3:0]                           viol_count_o,
  output logic [3:0]                           nonseq_count_o,
  output logic                                 first_viol_valid_o,
  output logic [ADDR_W-1:0]                    first_viol_addr_o,
  output logic [DATA_W-1:0]                    first_viol_data_o,
  output logic                                 done_o
);

  monitor_state_t   state_q, state_d;
  logic [3:0]       viol_q, viol_d, nonseq_q, nonseq_d;
  logic             fv_valid_q, fv_valid_d, done_q;
  logic [ADDR_W-1:0] fv_addr_q, fv_addr_d;
  logic [DATA_W-1:0] fv_data_q, fv_data_d;

  logic                   stats_clr, wr_ev, hit_any, miss;
  logic [NUM_REGIONS-1:0] hit_oh, hit_en, nonseq_pulse;

  // Scan from the top index down so the lowest matching region wins.
  always_comb begin
    hit_any = 1'b0;
    hit_oh  = '0;
    for (int r = int'(NUM_REGIONS) - 1; r >= 0; r--) begin
      if ((region_lo_i[r] <= sram_address_i) && (sram_address_i <= region_hi_i[r])) begin
        hit_any   = 1'b1;
        hit_oh    = '0;
        hit_oh[r] = 1'b1;
      end
    end
  end

  assign stats_clr = clear_i | start_i;
  assign wr_ev     = (state_q == S_MON_ARMED) & ~sram_we_n_i & ~stats_clr;
  assign hit_en    = hit_oh & {NUM_REGIONS{wr_ev}};
  assign miss      = wr_ev & ~hit_any;

  always_comb begin
    state_d    = state_q;
    viol_d     = viol_q;
    nonseq_d   = nonseq_q;
    fv_valid_d = fv_valid_q;
    fv_addr_d  = fv_addr_q;
    fv_data_d  = fv_data_q;
    if (clear_i) begin
      state_d = S_MON_IDLE;
    end else if (start_i) begin
      state_d = S_MON_ARMED;
    end else if (stop_i && state_q == S_MON_ARMED) begin
      state_d = S_MON_DONE;
    end
    if (stats_clr) begin
      viol_d     = '0;
      nonseq_d   = '0;
      fv_valid_d = 1'b0;
      fv_addr_d  = '0;
      fv_data_d  = '0;
    end else begin
      if (|nonseq_pulse) nonseq_d = 4'(sat_inc(32'(nonseq_q), 32'(MAX_VIOL)));
      if (miss) begin
        viol_d = 4'(sat_inc(32'(viol_q), 32'(MAX_VIOL)));
        if (!fv_valid_q) begin
          fv_valid_d = 1'b1;
          fv_addr_d  = sram_address_i;
          fv_data_d  = sram_write_data_i;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= S_MON_IDLE;
      viol_q     <= '0;
      nonseq_q   <= '0;
      fv_valid_q <= 1'b0;
      fv_addr_q  <= '0;
      fv_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      viol_q     <= viol_d;
      nonseq_q   <= nonseq_d;
      fv_valid_q <= fv_valid_d;
      fv_addr_q  <= fv_addr_d;
      fv_data_q  <= fv_data_d;
      done_q     <= (state_d == S_MON_DONE);
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    sram_region_tracker #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .CNT_W   (CNT_W),
      .SIG_POLY(SIG_POLY)
    ) u_tracker (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .clear_i (stats_clr),
      .hit_i   (hit_en[g]),
      .addr_i  (sram_address_i),
      .data_i  (sram_write_data_i),
      .count_o (region_count_o[g]),
      .sig_o   (signature_o[g]),
      .nonseq_o(nonseq_pulse[g])
    );
  end

  assign state_o            = state_q;
  assign viol_count_o       = viol_q;
  assign nonseq_count_o     = nonseq_q;
  assign first_viol_valid_o = fv_valid_q;
  assign first_viol_addr_o  = fv_addr_q;
  assign first_viol_data_o  = fv_data_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_sram_write_monitor.sv
// Directed bench for sram_write_monitor with hand-computed expected values.
module tb_sram_write_monitor;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, clr;
  logic [1:0][17:0] lo, hi;
  logic             we_n;
  logic [17:0]      addr;
  logic [15:0]      wdata;
  logic [1:0]       state;
  logic [1:0][17:0] rcount;
  logic [1:0][15:0] sig;
  logic [3:0]       viol, nonseq;
  logic             fv_valid, done;
  logic [17:0]      fv_addr;
  logic [15:0]      fv_data;

  int vectors = 0;
  int errors  = 0;

  always #10 clk = ~clk;

  sram_write_monitor dut (
    .Clock             (clk),
    .Resetn            (rst_n),
    .start_i           (start),
    .stop_i            (stop),
    .clear_i           (clr),
    .region_lo_i       (lo),
    .region_hi_i       (hi),
    .sram_we_n_i       (we_n),
    .sram_address_i    (addr),
    .sram_write_data_i (wdata),
    .state_o           (state),
    .region_count_o    (rcount),
    .signature_o       (sig),
    .viol_count_o      (viol),
    .nonseq_count_o    (nonseq),
    .first_viol_valid_o(fv_valid),
    .first_viol_addr_o (fv_addr),
    .first_viol_data_o (fv_data),
    .done_o            (done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d);
    we_n = 1'b0; addr = a; wdata = d;
    cyc();
    we_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
    we_n = 1'b1; addr = '0; wdata = '0;
    lo[0] = 18'd146944; hi[0] = 18'd262143;
    lo[1] = 18'd5;      hi[1] = 18'd3;
    cyc(); cyc();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count0", 32'(rcount[0]), 32'd0);
    chk("rst_sig0", 32'(sig[0]), 32'd0);
    chk("rst_viol", 32'(viol), 32'd0);
    chk("rst_fv_valid", 32'(fv_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Writes in IDLE are ignored.
    wr(18'd146944, 16'h1111);
    chk("idle_write", 32'(rcount[0]), 32'd0);

    // Sequential burst: MISR 0001,0000,0003,0002.
    pulse_start();
    chk("armed_state", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) wr(18'd146944 + 18'(i), 16'(i + 1));
    pulse_stop();
    chk("burst_count0", 32'(rcount[0]), 32'd4);
    chk("burst_nonseq", 32'(nonseq), 32'd0);
    chk("burst_viol", 32'(viol), 32'd0);
    chk("burst_state", 32'(state), 32'd2);
    chk("burst_done", 32'(done), 32'd1);
    chk("burst_sig0", 32'(sig[0]), 32'h0002);
    wr(18'd146950, 16'h5555);
    chk("done_write", 32'(rcount[0]), 32'd4);

    // Misses and first-violation capture; addr 4 is inside no region (region1 lo>hi).
    pulse_start();
    chk("start_clears", 32'(rcount[0]), 32'd0);
    wr(18'd100, 16'hBEEF);
    wr(18'd200, 16'h1234);
    chk("miss_viol", 32'(viol), 32'd2);
    chk("fv_addr", 32'(fv_addr), 32'd100);
    chk("fv_data", 32'(fv_data), 32'hBEEF);
    chk("fv_valid", 32'(fv_valid), 32'd1);
    wr(18'd4, 16'h0004);
    chk("inverted_region", 32'(viol), 32'd3);
    chk("region1_empty", 32'(rcount[1]), 32'd0);

    // Non-sequential writes; MISR 8000 -> 1021 -> 2042 exercises the polynomial.
    pulse_start();
    wr(18'd146944, 16'h8000);
    wr(18'd146946, 16'h0000);
    wr(18'd146946, 16'h0000);
    chk("nonseq_cnt", 32'(nonseq), 32'd2);
    chk("nonseq_count0", 32'(rcount[0]), 32'd3);
    chk("poly_sig0", 32'(sig[0]), 32'h2042);

    // Violation saturation.
    pulse_start();
    for (int i = 0; i < 20; i++) wr(18'd10 + 18'(i), 16'hA000 + 16'(i));
    chk("viol_sat", 32'(viol), 32'd15);
    chk("fv_keep_addr", 32'(fv_addr), 32'd10);
    chk("fv_keep_data", 32'(fv_data), 32'hA000);

    // Overlap resolves to region0; then a disjoint region1.
    lo[1] = 18'd146944; hi[1] = 18'd146950;
    pulse_start();
    wr(18'd146945, 16'h0001);
    chk("overlap_r0", 32'(rcount[0]), 32'd1);
    chk("overlap_r1", 32'(rcount[1]), 32'd0);
    lo[1] = 18'd1000; hi[1] = 18'd1003;
    wr(18'd1000, 16'h8000);
    wr(18'd1001, 16'h0000);
    chk("r1_count", 32'(rcount[1]), 32'd2);
    chk("r1_sig", 32'(sig[1]), 32'h1021);
    chk("r1_nonseq", 32'(nonseq), 32'd0);

    // stop with a write: counted.
    pulse_start();
    stop = 1'b1; we_n = 1'b0; addr = 18'd146944; wdata = 16'h0007;
    cyc();
    stop = 1'b0; we_n = 1'b1;
    chk("stop_wr_count", 32'(rcount[0]), 32'd1);
    chk("stop_wr_state", 32'(state), 32'd2);

    // start with a write: dropped.
    start = 1'b1; we_n = 1'b0; addr = 18'd146944; wdata = 16'h0009;
    cyc();
    start = 1'b0; we_n = 1'b1;
    chk("start_wr_count", 32'(rcount[0]), 32'd0);
    chk("start_wr_sig", 32'(sig[0]), 32'd0);
    chk("start_wr_state", 32'(state), 32'd1);

    // clear wins over start and stop.
    wr(18'd50, 16'h0050);
    wr(18'd146944, 16'h0001);
    clr = 1'b1; start = 1'b1; stop = 1'b1;
    cyc();
    clr = 1'b0; start = 1'b0; stop = 1'b0;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_viol", 32'(viol), 32'd0);
    chk("clr_fv_valid", 32'(fv_valid), 32'd0);
    chk("clr_count0", 32'(rcount[0]), 32'd0);

    // Reset mid-window discards everything.
    pulse_start();
    for (int i = 0; i < 10; i++) wr(18'd146944 + 18'(i), 16'h00F0 + 16'(i));
    chk("pre_rst_count0", 32'(rcount[0]), 32'd10);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_count0", 32'(rcount[0]), 32'd0);
    chk("mid_rst_sig0", 32'(sig[0]), 32'd0);
    wr(18'd146944, 16'h0001);
    chk("post_rst_idle", 32'(rcount[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
